// File: rtl/window_gen_3x3_if.sv
// window_gen_3x3_if: pixel-in / window-out stream bundle for window_gen_3x3.
interface window_gen_3x3_if #(
  parameter int WIDTH = 320,
  parameter int HEIGHT = 240,
  parameter int PIXEL_WIDTH = 24
);
  logic [PIXEL_WIDTH-1:0] in_pixel;
  logic in_valid, in_sof, in_ready;
  logic [9*PIXEL_WIDTH-1:0] win;
  logic win_valid, win_ready, win_last, sync_err;
  logic [$clog2(WIDTH)-1:0] win_x;
  logic [$clog2(HEIGHT)-1:0] win_y;
  modport slave (
    input in_pixel, in_valid, in_sof, win_ready,
    output in_ready, win, win_valid, win_x, win_y, win_last, sync_err
  );
  modport master (
    output in_pixel, in_valid, in_sof, win_ready,
    input in_ready, win, win_valid, win_x, win_y, win_last, sync_err
  );
endinterface

// File: rtl/window_gen_3x3.sv
// window_gen_3x3: streaming 3x3 neighbourhood generator built on two line buffers.
// Define WINDOW_REPLICATE_EN to edge-replicate out-of-frame slots instead of zero padding.
module window_gen_3x3 #(
  parameter int WIDTH = 320,
  parameter int HEIGHT = 240,
  parameter int PIXEL_WIDTH = 24
) (
  input logic clk,
  input logic rst_n,
  window_gen_3x3_if.slave bus
);
  localparam int PW = PIXEL_WIDTH;
  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam int IW = $clog2(HEIGHT + 2);
  localparam logic [1:0] FILL = 2'd0, STREAM = 2'd1, FLUSH = 2'd2;
  logic [1:0] state_q, state_d;
  logic run_q;
  logic [XW-1:0] in_x_q, in_x_d, cx_q, cx_d, win_x_q, addr;
  logic [IW-1:0] in_y_q, in_y_d;
  logic [YW-1:0] cy_q, cy_d, win_y_q;
  logic win_valid_q, win_last_q, sync_err_q;
  logic [9*PW-1:0] win_q, win_d;
  logic [PW-1:0] lb0_q [WIDTH];
  logic [PW-1:0] lb1_q [WIDTH];
  logic [PW-1:0] ca_q [3];
  logic [PW-1:0] cb_q [3];
  logic [PW-1:0] cn [3];
  logic [PW-1:0] hv [3][3];
  logic [PW-1:0] wv [3][3];
  logic free, consume, accept, resync, step, gen;
  logic at_l, at_r, at_t, at_b, in_end, fill_end;
  assign free = !win_valid_q || bus.win_ready;
  assign consume = win_valid_q && bus.win_ready;
  assign bus.in_ready = run_q && (state_q == FILL || (state_q == STREAM && free));
  assign accept = bus.in_valid && bus.in_ready;
  assign resync = accept && bus.in_sof && (in_x_q != '0 || in_y_q != '0);
  // Flush clocks virtual pixels through the pipe until the last window is out.
  assign step = state_q == FLUSH ? free && !win_last_q : accept;
  assign gen = step && !resync && state_q != FILL;
  assign addr = resync ? '0 : in_x_q;
  assign cn[0] = lb1_q[addr];
  assign cn[1] = lb0_q[addr];
  assign cn[2] = state_q == FLUSH ? '0 : bus.in_pixel;
  assign at_l = cx_q == '0;
  assign at_r = cx_q == XW'(WIDTH - 1);
  assign at_t = cy_q == '0;
  assign at_b = cy_q == YW'(HEIGHT - 1);
  assign in_end = in_x_q == XW'(WIDTH - 1) && in_y_q == IW'(HEIGHT - 1);
  assign fill_end = in_x_q == '0 && in_y_q == IW'(1);
  // Columns: stored left, stored centre, incoming right; columns first, then rows.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
`ifdef WINDOW_REPLICATE_EN
      hv[r][0] = at_l ? cb_q[r] : ca_q[r];
      hv[r][2] = at_r ? cb_q[r] : cn[r];
`else
      hv[r][0] = at_l ? '0 : ca_q[r];
      hv[r][2] = at_r ? '0 : cn[r];
`endif
      hv[r][1] = cb_q[r];
    end
    for (int c = 0; c < 3; c++) begin
`ifdef WINDOW_REPLICATE_EN
      wv[0][c] = at_t ? hv[1][c] : hv[0][c];
      wv[2][c] = at_b ? hv[1][c] : hv[2][c];
`else
      wv[0][c] = at_t ? '0 : hv[0][c];
      wv[2][c] = at_b ? '0 : hv[2][c];
`endif
      wv[1][c] = hv[1][c];
    end
    win_d = '0;
    for (int k = 0; k < 9; k++) win_d[k*PW +: PW] = wv[k/3][k%3];
  end
  always_comb begin
    state_d = state_q;
    in_x_d = in_x_q;
    in_y_d = in_y_q;
    cx_d = cx_q;
    cy_d = cy_q;
    if (step) begin
      in_x_d = in_x_q == XW'(WIDTH - 1) ? '0 : in_x_q + 1'b1;
      in_y_d = in_x_q == XW'(WIDTH - 1) ? in_y_q + 1'b1 : in_y_q;
    end
    if (gen) begin
      cx_d = at_r ? '0 : cx_q + 1'b1;
      cy_d = at_r ? cy_q + 1'b1 : cy_q;
    end
    if (state_q == FILL && accept && fill_end) state_d = STREAM;
    if (state_q == STREAM && accept && in_end) state_d = FLUSH;
    if (resync) begin
      state_d = FILL;
      in_x_d = XW'(1);
      in_y_d = '0;
      cx_d = '0;
      cy_d = '0;
    end
    if (state_q == FLUSH && consume && win_last_q) begin
      state_d = FILL;
      in_x_d = '0;
      in_y_d = '0;
      cx_d = '0;
      cy_d = '0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      run_q <= 1'b0;
      in_x_q <= '0;
      in_y_q <= '0;
      cx_q <= '0;
      cy_q <= '0;
      win_q <= '0;
      win_valid_q <= 1'b0;
      win_x_q <= '0;
      win_y_q <= '0;
      win_last_q <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q <= 1'b1;
      in_x_q <= in_x_d;
      in_y_q <= in_y_d;
      cx_q <= cx_d;
      cy_q <= cy_d;
      sync_err_q <= sync_err_q | resync;
      if (gen) begin
        win_q <= win_d;
        win_valid_q <= 1'b1;
        win_x_q <= cx_q;
        win_y_q <= cy_q;
        win_last_q <= at_r && at_b;
      end else if (resync || consume) begin
        win_valid_q <= 1'b0;
        win_last_q <= 1'b0;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (step) begin
      lb1_q[addr] <= cn[1];
      lb0_q[addr] <= cn[2];
      ca_q <= cb_q;
      cb_q <= cn;
    end
  end
  assign bus.win = win_q;
  assign bus.win_valid = win_valid_q;
  assign bus.win_x = win_x_q;
  assign bus.win_y = win_y_q;
  assign bus.win_last = win_last_q;
  assign bus.sync_err = sync_err_q;
endmodule

// File: doc/window_gen_3x3.md
Name: window_gen_3x3

Overview:
- Streaming 3x3 neighbourhood generator that sits directly upstream of the superresolution core.
- Accepts a raster-order pixel stream from the capture path, holds two line buffers, and emits one 3x3 window per input pixel position.
- Each window carries its centre coordinates; borders are zero-padded.
- Replaces frame-buffer neighbourhood fetching with a single-pass pipeline.

Parameters:
- WIDTH, 320, pixels per line.
- HEIGHT, 240, lines per frame.
- PIXEL_WIDTH, 24, bits per pixel (RGB888).

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_pixel  in  PIXEL_WIDTH  input pixel, raster order.
- in_valid  in  1  in_pixel valid.
- in_sof  in  1  start of frame; qualified by in_valid.
- in_ready  out  1  block accepts in_pixel this cycle.
- win  out  9*PIXEL_WIDTH  window; slot k at [k*PIXEL_WIDTH +: PIXEL_WIDTH].
- win_valid  out  1  win, win_x, win_y, win_last valid.
- win_ready  in  1  downstream accepts the window.
- win_x  out  $clog2(WIDTH)  centre column.
- win_y  out  $clog2(HEIGHT)  centre row.
- win_last  out  1  window centred on (WIDTH-1, HEIGHT-1).
- sync_err  out  1  sticky; in_sof arrived at a nonzero position.

Behaviour:
- Reset (async, rst_n low): in_ready=0, win_valid=0, win=0, win_x=0, win_y=0, win_last=0, sync_err=0, state FILL, all counters 0. Line-buffer contents are don't-care.
- Acceptance: a pixel is accepted when in_valid && in_ready.
- Window emission: a window is consumed when win_valid && win_ready. win_valid holds, and win/win_x/win_y/win_last stay stable, until the window is consumed.
- Slot order: 0 TL, 1 T, 2 TR, 3 L, 4 C, 5 R, 6 BL, 7 B, 8 BR.
- Zero padding: slots outside the frame are 0.
  - Top slots (0,1,2) when y==0.
  - Left slots (0,3,6) when x==0.
  - Right slots (2,5,8) when x==WIDTH-1.
  - Bottom slots (6,7,8) when y==HEIGHT-1.
  - No wrap-around of pixels across lines or frames.
- Input counter: in_cnt runs 0..WIDTH*HEIGHT-1. The window centred on pixel index n is complete once pixel n+WIDTH+1 is accepted.
- FILL state:
  - in_ready=1; accept the first WIDTH+1 pixels, no output.
  - On acceptance of pixel index WIDTH (0-based), go to STREAM.
- STREAM state:
  - in_ready = !win_valid || win_ready.
  - Each accepted pixel registers one new window; win_valid rises the cycle after acceptance.
  - Latency: the window for centre index n appears one cycle after pixel n+WIDTH+1 is accepted.
  - On acceptance of pixel WIDTH*HEIGHT-1, go to FLUSH.
- FLUSH state:
  - in_ready=0.
  - Emit the remaining WIDTH+1 windows, one per consumed window (back-to-back when win_ready=1). Bottom-row windows carry zero bottom slots.
  - After the window with win_last=1 is consumed: go to FILL, in_cnt=0.
- Frame consistency: exactly WIDTH*HEIGHT windows per frame, in raster order of centre.
- in_sof:
  - Accepted with in_sof=1 while in_cnt!=0, or in STREAM: set sync_err=1, discard any pending window, restart in FILL treating this pixel as index 0.
  - in_sof=1 at in_cnt==0 is normal.
  - in_sof=0 at index 0 is accepted; no error.
- Simultaneous consume and accept in STREAM: the new window replaces the consumed one in the same cycle; no bubble.
- Degenerate sizes: WIDTH>=2 and HEIGHT>=2 are required; smaller values are unsupported.
- Line buffers: two WIDTH-deep PIXEL_WIDTH memories, one read and one write per accepted pixel, single-port inferable.

Optional Feature:
- Macro: WINDOW_REPLICATE_EN.
- Defined: out-of-frame slots take the nearest in-frame pixel (edge replicate) instead of 0. Corners replicate the corner pixel. Timing and handshake unchanged.
- Undefined: zero padding as above.

Test Plan:
- WIDTH=4, HEIGHT=3, pixels 1..12, in_valid=1, win_ready=1 throughout:
  - win_valid first rises 1 cycle after pixel 6 is accepted.
  - (0,0)=[0,0,0,0,1,2,0,5,6]
  - (1,1)=[1,2,3,5,6,7,9,10,11]
  - (3,2)=[7,8,0,11,12,0,0,0,0] with win_last=1.
  - 12 windows total.
- Same stimulus with win_ready toggled 1/0 every cycle: identical window sequence; win held stable while win_ready=0; in_ready=0 whenever a window is pending and win_ready=0.
- Same stimulus with WINDOW_REPLICATE_EN defined: (0,0)=[1,1,2,1,1,2,5,5,6]; (3,2)=[7,8,8,11,12,12,11,12,12].
- Two back-to-back frames (second frame = 13..24): 24 windows; second frame (0,0)=[0,0,0,0,13,14,0,17,18]; sync_err stays 0.
- in_sof=1 injected at pixel index 7: sync_err=1; next windows start at (0,0) centred on that pixel; frame completes 12 windows later.
- rst_n pulsed low mid-STREAM: all outputs at reset values immediately (asynchronous); the next frame produces the correct full sequence.
